// File: rtl/pipe_stage_skid_reg.sv
// Inter-stage pipeline register with a valid/ready handshake, an optional
// skid entry for registered back-pressure, and a control field that is
// zeroed on flush. Priority each cycle: rst > flush > freeze > normal.
module pipe_stage_skid_reg #(
    parameter int DATA_W = 128,
    parameter int CTRL_W = 8,
    parameter int SKID   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              freeze,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        occupancy
);

    logic              h_valid_q, h_valid_d;
    logic [DATA_W-1:0] h_data_q,  h_data_d;
    logic [CTRL_W-1:0] h_ctrl_q,  h_ctrl_d;
    logic              s_valid_q, s_valid_d;
    logic [DATA_W-1:0] s_data_q,  s_data_d;
    logic [CTRL_W-1:0] s_ctrl_q,  s_ctrl_d;
    logic              accept, drain;

    // Handshake outputs; with a skid entry in_ready depends on registers only.
    always_comb begin
        if (SKID != 0) in_ready = !s_valid_q && !freeze;
        else           in_ready = (!h_valid_q || out_ready) && !freeze;
        out_valid = h_valid_q && !freeze;
        out_ctrl  = h_valid_q ? h_ctrl_q : '0;
        out_data  = h_data_q;
        occupancy = {1'b0, h_valid_q} + {1'b0, s_valid_q};
        accept    = in_valid && in_ready;
        drain     = out_valid && out_ready;
    end

    // Next-state for head/skid entries; flush clears valid and ctrl but keeps data.
    always_comb begin
        h_valid_d = h_valid_q;
        h_data_d  = h_data_q;
        h_ctrl_d  = h_ctrl_q;
        s_valid_d = s_valid_q;
        s_data_d  = s_data_q;
        s_ctrl_d  = s_ctrl_q;
        if (flush) begin
            h_valid_d = 1'b0;
            h_ctrl_d  = '0;
            s_valid_d = 1'b0;
            s_ctrl_d  = '0;
        end else if (!freeze) begin
            if (SKID != 0) begin
                if (drain && s_valid_q) begin
                    // in_ready is low while skid is full, so no accept here
                    h_valid_d = 1'b1;
                    h_data_d  = s_data_q;
                    h_ctrl_d  = s_ctrl_q;
                    s_valid_d = 1'b0;
                end else if (drain) begin
                    if (accept) begin
                        h_data_d = in_data;
                        h_ctrl_d = in_ctrl;
                    end else begin
                        h_valid_d = 1'b0;
                    end
                end else if (h_valid_q && accept) begin
                    s_valid_d = 1'b1;
                    s_data_d  = in_data;
                    s_ctrl_d  = in_ctrl;
                end else if (accept) begin
                    h_valid_d = 1'b1;
                    h_data_d  = in_data;
                    h_ctrl_d  = in_ctrl;
                end
            end else begin
                if (accept) begin
                    h_valid_d = 1'b1;
                    h_data_d  = in_data;
                    h_ctrl_d  = in_ctrl;
                end else if (drain) begin
                    h_valid_d = 1'b0;
                end
            end
        end
    end

    // State registers with synchronous reset clearing everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            h_valid_q <= 1'b0;
            h_data_q  <= '0;
            h_ctrl_q  <= '0;
            s_valid_q <= 1'b0;
            s_data_q  <= '0;
            s_ctrl_q  <= '0;
        end else begin
            h_valid_q <= h_valid_d;
            h_data_q  <= h_data_d;
            h_ctrl_q  <= h_ctrl_d;
            s_valid_q <= s_valid_d;
            s_data_q  <= s_data_d;
            s_ctrl_q  <= s_ctrl_d;
        end
    end

endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
// Drives a SKID=1/128-bit and a SKID=0/32-bit instance with identical
// control stimulus and compares both against queue-based FIFO models.
module tb_pipe_stage_skid_reg;

    logic         clk = 1'b0;
    logic         rst, flush, freeze, in_valid, out_ready;
    logic [127:0] in_data;
    logic [7:0]   in_ctrl;

    logic         rdy1, ov1, rdy0, ov0;
    logic [127:0] od1;
    logic [31:0]  od0;
    logic [7:0]   oc1, oc0;
    logic [1:0]   occ1, occ0;

    int checks = 0;
    int errors = 0;
    bit known  = 1'b0;

    // Models: queue entries are {ctrl, data}; hd tracks the head data register.
    logic [135:0] q1[$];
    logic [39:0]  q0[$];
    logic [127:0] hd1;
    logic [31:0]  hd0;

    always #5 clk = ~clk;

    pipe_stage_skid_reg #(.DATA_W(128), .CTRL_W(8), .SKID(1)) dut1 (
        .clk(clk), .rst(rst), .flush(flush), .freeze(freeze),
        .in_valid(in_valid), .in_ready(rdy1), .in_data(in_data), .in_ctrl(in_ctrl),
        .out_valid(ov1), .out_ready(out_ready), .out_data(od1), .out_ctrl(oc1),
        .occupancy(occ1));

    pipe_stage_skid_reg #(.DATA_W(32), .CTRL_W(8), .SKID(0)) dut0 (
        .clk(clk), .rst(rst), .flush(flush), .freeze(freeze),
        .in_valid(in_valid), .in_ready(rdy0), .in_data(in_data[31:0]), .in_ctrl(in_ctrl),
        .out_valid(ov0), .out_ready(out_ready), .out_data(od0), .out_ctrl(oc0),
        .occupancy(occ0));

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One cycle: drive inputs, check outputs against the model, then advance the model.
    task automatic step(input bit iv, input logic [7:0] c, input bit ordy,
                        input bit fl, input bit fz, input bit r);
        bit e_rdy1, e_ov1, e_rdy0, e_ov0;
        @(negedge clk);
        rst = r; flush = fl; freeze = fz; in_valid = iv; out_ready = ordy; in_ctrl = c;
        in_data = {$urandom, $urandom, $urandom, $urandom};
        #1;
        e_rdy1 = (q1.size() < 2) && !fz;
        e_ov1  = (q1.size() > 0) && !fz;
        e_rdy0 = (q0.size() == 0 || ordy) && !fz;
        e_ov0  = (q0.size() > 0) && !fz;
        if (known) begin
            chk("s1_in_ready",  128'(rdy1), 128'(e_rdy1));
            chk("s1_out_valid", 128'(ov1),  128'(e_ov1));
            chk("s1_out_ctrl",  128'(oc1),  (q1.size() > 0) ? 128'(q1[0][135:128]) : 128'(0));
            chk("s1_out_data",  od1, hd1);
            chk("s1_occupancy", 128'(occ1), 128'(q1.size()));
            chk("s0_in_ready",  128'(rdy0), 128'(e_rdy0));
            chk("s0_out_valid", 128'(ov0),  128'(e_ov0));
            chk("s0_out_ctrl",  128'(oc0),  (q0.size() > 0) ? 128'(q0[0][39:32]) : 128'(0));
            chk("s0_out_data",  128'(od0),  128'(hd0));
            chk("s0_occupancy", 128'(occ0), 128'(q0.size()));
        end
        @(posedge clk);
        if (r) begin
            q1.delete(); q0.delete(); hd1 = '0; hd0 = '0; known = 1'b1;
        end else if (fl) begin
            q1.delete(); q0.delete();
        end else if (!fz) begin
            if (e_ov1 && ordy) void'(q1.pop_front());
            if (iv && e_rdy1)  q1.push_back({c, in_data});
            if (e_ov0 && ordy) void'(q0.pop_front());
            if (iv && e_rdy0)  q0.push_back({c, in_data[31:0]});
        end
        if (q1.size() > 0) hd1 = q1[0][127:0];
        if (q0.size() > 0) hd0 = q0[0][31:0];
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; freeze = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_data = '0; in_ctrl = '0;
        hd1 = '0; hd0 = '0;
        // reset, then reset values
        step(0, 8'h00, 0, 0, 0, 1);
        step(0, 8'h00, 0, 0, 0, 0);
        // streaming ctrl 1..5 with out_ready high
        for (int i = 1; i <= 5; i++) step(1, 8'(i), 1, 0, 0, 0);
        step(0, 8'h00, 1, 0, 0, 0);
        step(0, 8'h00, 1, 0, 0, 0);
        // back-pressure: A, B, C with out_ready low, then drain
        step(1, 8'h0A, 0, 0, 0, 0);
        step(1, 8'h0B, 0, 0, 0, 0);
        step(1, 8'h0C, 0, 0, 0, 0);
        step(1, 8'h0C, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 8'h00, 1, 0, 0, 0);
        // flush with two entries held and an incoming 0xFF
        step(1, 8'h21, 0, 0, 0, 0);
        step(1, 8'h22, 0, 0, 0, 0);
        step(1, 8'hFF, 0, 1, 0, 0);
        step(0, 8'h00, 1, 0, 0, 0);
        step(0, 8'h00, 1, 0, 0, 0);
        // freeze three cycles holding head 0x12
        step(1, 8'h12, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(1, 8'h33, 1, 0, 1, 0);
        step(0, 8'h00, 1, 0, 0, 0);
        step(0, 8'h00, 1, 0, 0, 0);
        // flush and freeze together: flush wins
        step(1, 8'h41, 0, 0, 0, 0);
        step(1, 8'h42, 0, 0, 0, 0);
        step(0, 8'h00, 0, 1, 1, 0);
        step(0, 8'h00, 1, 0, 0, 0);
        // reset mid back-pressure
        step(1, 8'h51, 0, 0, 0, 0);
        step(1, 8'h52, 0, 0, 0, 0);
        step(0, 8'h00, 0, 0, 0, 1);
        step(0, 8'h00, 0, 0, 0, 0);
        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(3, 0) != 0, 8'($urandom), $urandom_range(2, 0) != 0,
                 $urandom_range(15, 0) == 0, $urandom_range(7, 0) == 0,
                 $urandom_range(63, 0) == 0);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
